// File: rtl/byte_stream_fifo.sv
// byte_stream_fifo: valid/ready FIFO that shows INIT on O while empty, with occupancy count and sync flush.
module byte_stream_fifo #(
    parameter int unsigned          WIDTH = 8,
    parameter int unsigned          DEPTH = 4,
    parameter logic [WIDTH-1:0]     INIT  = 8'hDE
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESETN,
    input  logic                        FLUSH,
    input  logic [WIDTH-1:0]            I,
    input  logic                        I_VALID,
    output logic                        I_READY,
    output logic [WIDTH-1:0]            O,
    output logic                        O_VALID,
    input  logic                        O_READY,
    output logic [$clog2(DEPTH):0]      COUNT
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    assign I_READY = count_q != CW'(DEPTH);
    assign O_VALID = count_q != '0;
    assign O       = O_VALID ? mem_q[rd_q] : INIT;
    assign COUNT   = count_q;
    assign push    = I_VALID & I_READY;
    assign pop     = O_VALID & O_READY;
    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_comb begin
        wr_d    = FLUSH ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d    = FLUSH ? '0 : pop ? rd_q + AW'(1) : rd_q;
        count_d = FLUSH ? '0 : (push & ~pop) ? count_q + CW'(1) :
                  (pop & ~push) ? count_q - CW'(1) : count_q;
    end
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= INIT;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (push && !FLUSH) mem_q[wr_q] <= I;
        end
    end
endmodule
